switch_debounce: RTL and testbench



---
 rtl/switch_debounce_pkg.sv | 23 ++
 rtl/switch_debounce_bit.sv | 84 ++++++++
 rtl/switch_debounce.sv | 91 +++++++++
 tb/tb_switch_debounce.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the switch debounce block: default widths and timing,
// the switch vector type, and the counter-width helper used by the per-bit
// debouncer.
// -----------------------------------------------------------------------------
package switch_pkg;

    // Number of board switches feeding the AHB switch peripheral.
    localparam int SW_WIDTH = 8;

    // Default number of stable HCLK cycles needed before a new level is accepted.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    // One bit per board switch.
    typedef logic [SW_WIDTH-1:0] sw_vec_t;

    // Width of a counter that must hold values 0 .. cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// -----------------------------------------------------------------------------
// switch_debounce_bit
// Conditions one raw switch pin: a SYNC_STAGES-deep synchroniser followed by a
// stability counter. The accepted level is held in the stable flop, and accept
// marks the edge on which a new level is taken.
//
// Ports:
//   clk     in   clock; every flop uses its rising edge
//   rst     in   synchronous active-high reset
//   raw     in   asynchronous switch pin
//   stable  out  debounced level (registered)
//   accept  out  high during the cycle whose rising edge loads a new level
// -----------------------------------------------------------------------------
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic accept
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
    // Count reached on the last mismatching cycle before acceptance.
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next_s;
    logic                   stable_r;
    logic                   stable_next_s;
    logic                   accept_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain: the only place the raw pin is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Stability counter and acceptance decision.
    always_comb begin
        cnt_next_s    = cnt_r;
        stable_next_s = stable_r;
        accept_s      = 1'b0;
        if (sync_s == stable_r) begin
            // Back at (or still at) the accepted level: any partial count is void.
            cnt_next_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            // Clearing here is what keeps the counter from ever wrapping.
            cnt_next_s    = CNT_ZERO;
            stable_next_s = sync_s;
            accept_s      = 1'b1;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Counter and accepted-level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            stable_r <= stable_next_s;
        end
    end

    assign stable = stable_r;
    assign accept = accept_s;

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Input conditioning for the AHB switch peripheral: synchronises and debounces
// each board switch independently and flags debounced changes.
//
// Ports:
//   HCLK              in   system clock, rising edge
//   HRESET            in   synchronous active-high reset
//   SwitchesRaw       in   raw asynchronous switch pins
//   Switches          out  debounced levels (to the AHB switch peripheral)
//   SwitchChange      out  one-cycle pulse when any debounced bit changes
//   SwitchChangeMask  out  bits that changed, zero when SwitchChange is low
//   SwitchIrqClr      in   interrupt clear request  (SWITCH_DEBOUNCE_IRQ_EN only)
//   SwitchIrq         out  sticky change interrupt  (SWITCH_DEBOUNCE_IRQ_EN only)
//
// Build option: define SWITCH_DEBOUNCE_IRQ_EN to add the sticky interrupt.
// -----------------------------------------------------------------------------
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [WIDTH-1:0] SwitchesRaw,
    output logic [WIDTH-1:0] Switches,
    output logic             SwitchChange,
    output logic [WIDTH-1:0] SwitchChangeMask
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    ,
    input  logic             SwitchIrqClr,
    output logic             SwitchIrq
`endif
);

    logic [WIDTH-1:0] accept_s;
    logic             change_r;
    logic [WIDTH-1:0] mask_r;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_bit (
            .clk    (HCLK),
            .rst    (HRESET),
            .raw    (SwitchesRaw[g]),
            .stable (Switches[g]),
            .accept (accept_s[g])
        );
    end

    // Change flags, registered on the same edge that loads the new levels so
    // they line up with Switches.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            change_r <= 1'b0;
            mask_r   <= {WIDTH{1'b0}};
        end else begin
            change_r <= |accept_s;
            mask_r   <= accept_s;
        end
    end

    assign SwitchChange     = change_r;
    assign SwitchChangeMask = mask_r;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    logic irq_r;

    // Sticky interrupt; a coincident set beats the clear so no change is lost.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_r <= 1'b0;
        end else if (|accept_s) begin
            irq_r <= 1'b1;
        end else if (SwitchIrqClr) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign SwitchIrq = irq_r;
`else
    // No interrupt logic in this build.
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
// Self-checking bench for switch_debounce (WIDTH=8, DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2). The reference model keeps the full input history and
// decides acceptance as "the synchronised level has differed from the accepted
// level on each of the last DEBOUNCE_CYCLES non-reset edges".
// -----------------------------------------------------------------------------
module tb_switch_debounce;
    import switch_pkg::*;

    localparam int D    = 4;
    localparam int SYNC = 2;
    localparam int MAXE = 2048;

    logic    HCLK;
    logic    HRESET;
    sw_vec_t SwitchesRaw;
    sw_vec_t Switches;
    logic    SwitchChange;
    sw_vec_t SwitchChangeMask;
    logic    SwitchIrqClr;
    logic    SwitchIrq;

    int n_checks = 0;
    int n_fail   = 0;

    // Input history, one entry per rising edge.
    sw_vec_t raw_hist [0:MAXE-1];
    bit      rst_hist [0:MAXE-1];
    bit      clr_hist [0:MAXE-1];
    int      n_edge = 0;

    // Model outputs after the most recent edge.
    sw_vec_t m_sw   = 8'h00;
    logic    m_chg  = 1'b0;
    sw_vec_t m_mask = 8'h00;
    logic    m_irq  = 1'b0;

    switch_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .HCLK             (HCLK),
        .HRESET           (HRESET),
        .SwitchesRaw      (SwitchesRaw),
        .Switches         (Switches),
        .SwitchChange     (SwitchChange),
        .SwitchChangeMask (SwitchChangeMask)
`ifdef SWITCH_DEBOUNCE_IRQ_EN
        ,
        .SwitchIrqClr     (SwitchIrqClr),
        .SwitchIrq        (SwitchIrq)
`endif
    );

`ifndef SWITCH_DEBOUNCE_IRQ_EN
    assign SwitchIrq = 1'b0;
`endif

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Synchronised level seen by the debouncer just before edge e.
    function automatic sw_vec_t s_at(input int e);
        for (int k = 1; k <= SYNC; k++) begin
            if (e - k < 0 || rst_hist[e-k]) return 8'h00;
        end
        return raw_hist[e-SYNC];
    endfunction

    // Advance the model across edge e.
    function automatic void model_step(input int e);
        sw_vec_t acc;
        sw_vec_t sv;
        bit ok;
        if (rst_hist[e]) begin
            m_sw = 8'h00; m_chg = 1'b0; m_mask = 8'h00; m_irq = 1'b0;
        end else begin
            acc = 8'h00;
            for (int i = 0; i < 8; i++) begin
                ok = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (e - j < 0 || rst_hist[e-j]) begin
                        ok = 1'b0;
                    end else begin
                        sv = s_at(e - j);
                        if (sv[i] == m_sw[i]) ok = 1'b0;
                    end
                end
                acc[i] = ok;
            end
            m_sw   = m_sw ^ acc;
            m_mask = acc;
            m_chg  = |acc;
            if (|acc) m_irq = 1'b1;
            else if (clr_hist[e]) m_irq = 1'b0;
        end
    endfunction

    // One clock: record the inputs seen at the edge, update the model, then
    // step 1 time unit past the edge so outputs can be sampled.
    task automatic tick();
        @(posedge HCLK);
        if (n_edge >= MAXE) begin
            $display("FAIL history_overflow edges=%0d limit=%0d", n_edge, MAXE);
            $fatal(1);
        end
        raw_hist[n_edge] = SwitchesRaw;
        rst_hist[n_edge] = HRESET;
        clr_hist[n_edge] = SwitchIrqClr;
        model_step(n_edge);
        n_edge++;
        #1;
    endtask

    task automatic settle(input int cycles);
        SwitchesRaw = 8'h00;
        for (int k = 0; k < cycles; k++) tick();
    endtask

    task automatic test_reset();
        HRESET = 1'b1; SwitchesRaw = 8'hFF; SwitchIrqClr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({Switches, SwitchChange, SwitchChangeMask} !== {8'h00, 1'b0, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got sw=%h chg=%b mask=%h want 00/0/00", k, Switches, SwitchChange, SwitchChangeMask);
            end
        end
        HRESET = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++;
            if (Switches !== ((k >= 6) ? 8'hFF : 8'h00) || SwitchChange !== (k == 6) ||
                SwitchChangeMask !== ((k == 6) ? 8'hFF : 8'h00)) begin
                n_fail++;
                $display("FAIL reset_release k=%0d got sw=%h chg=%b mask=%h", k, Switches, SwitchChange, SwitchChangeMask);
            end
        end
    endtask

    task automatic test_clean_step();
        settle(12);
        SwitchesRaw = 8'h05;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++;
            if (Switches !== ((k >= 6) ? 8'h05 : 8'h00) || SwitchChange !== (k == 6) ||
                SwitchChangeMask !== ((k == 6) ? 8'h05 : 8'h00)) begin
                n_fail++;
                $display("FAIL clean_step k=%0d got sw=%h chg=%b mask=%h", k, Switches, SwitchChange, SwitchChangeMask);
            end
        end
    endtask

    task automatic test_glitch();
        int widths [2] = '{3, 2};
        settle(12);
        // Short pulses on bit 3 must never reach Switches.
        foreach (widths[w]) begin
            for (int k = 1; k <= 10; k++) begin
                SwitchesRaw = (k <= widths[w]) ? 8'h08 : 8'h00;
                tick();
                n_checks++;
                if (Switches !== 8'h00 || SwitchChange !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_reject width=%0d k=%0d got sw=%h chg=%b want 00/0", widths[w], k, Switches, SwitchChange);
                end
            end
        end
        // A 5-cycle pulse is long enough: accepted, then released again.
        for (int k = 1; k <= 14; k++) begin
            SwitchesRaw = (k <= 5) ? 8'h08 : 8'h00;
            tick();
            n_checks++;
            if (Switches !== ((k >= 6 && k <= 10) ? 8'h08 : 8'h00) ||
                SwitchChange !== (k == 6 || k == 11) ||
                SwitchChangeMask !== ((k == 6 || k == 11) ? 8'h08 : 8'h00)) begin
                n_fail++;
                $display("FAIL glitch_accept k=%0d got sw=%h chg=%b mask=%h", k, Switches, SwitchChange, SwitchChangeMask);
            end
        end
    endtask

    task automatic test_independent_bits();
        settle(12);
        for (int k = 1; k <= 12; k++) begin
            SwitchesRaw = (k >= 3) ? 8'h81 : 8'h01;
            tick();
            n_checks++;
            if (SwitchChange !== (k == 6 || k == 8) ||
                SwitchChangeMask !== ((k == 6) ? 8'h01 : (k == 8) ? 8'h80 : 8'h00) ||
                {SwitchChange, SwitchChangeMask, Switches} !== {m_chg, m_mask, m_sw}) begin
                n_fail++;
                $display("FAIL independent_bits k=%0d got sw=%h chg=%b mask=%h model sw=%h", k, Switches, SwitchChange, SwitchChangeMask, m_sw);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        settle(12);
        SwitchesRaw = 8'h02;
        for (int k = 1; k <= 4; k++) tick();
        HRESET = 1'b1;
        tick();
        n_checks++;
        if (Switches !== 8'h00 || SwitchChange !== 1'b0 || SwitchChangeMask !== 8'h00) begin
            n_fail++;
            $display("FAIL midcount_in_reset got sw=%h chg=%b mask=%h want 00/0/00", Switches, SwitchChange, SwitchChangeMask);
        end
        HRESET = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            tick();
            n_checks++;
            if (Switches !== ((r >= 6) ? 8'h02 : 8'h00) || SwitchChange !== (r == 6) ||
                SwitchChangeMask !== ((r == 6) ? 8'h02 : 8'h00)) begin
                n_fail++;
                $display("FAIL midcount_release r=%0d got sw=%h chg=%b mask=%h", r, Switches, SwitchChange, SwitchChangeMask);
            end
        end
    endtask

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    task automatic test_irq();
        settle(12);
        SwitchIrqClr = 1'b1; tick(); SwitchIrqClr = 1'b0;
        SwitchesRaw = 8'h10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (SwitchIrq !== (k >= 6)) begin
                n_fail++;
                $display("FAIL irq_set k=%0d got irq=%b want %b", k, SwitchIrq, (k >= 6));
            end
        end
        // Clear on the very edge of a new acceptance: the set must win.
        SwitchesRaw = 8'h30;
        for (int k = 1; k <= 6; k++) begin
            SwitchIrqClr = (k == 6);
            tick();
        end
        SwitchIrqClr = 1'b0;
        n_checks++;
        if (SwitchIrq !== 1'b1 || SwitchChangeMask !== 8'h20) begin
            n_fail++;
            $display("FAIL irq_set_wins got irq=%b mask=%h want 1/20", SwitchIrq, SwitchChangeMask);
        end
        tick();
        n_checks++;
        if (SwitchIrq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_sticky got irq=%b want 1", SwitchIrq);
        end
        SwitchIrqClr = 1'b1; tick(); SwitchIrqClr = 1'b0;
        n_checks++;
        if (SwitchIrq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear got irq=%b want 0", SwitchIrq);
        end
    endtask
`endif

    task automatic test_random();
        sw_vec_t cur = 8'h00;
        int      hold = 0;
        for (int k = 0; k < 500; k++) begin
            if (hold == 0) begin
                cur  = cur ^ (8'($urandom) & 8'($urandom));
                hold = $urandom_range(1, 8);
            end
            hold--;
            SwitchesRaw  = cur;
            HRESET       = ($urandom_range(0, 99) == 0);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
            SwitchIrqClr = ($urandom_range(0, 3) == 0);
`endif
            tick();
            n_checks++;
            if ({Switches, SwitchChange, SwitchChangeMask} !== {m_sw, m_chg, m_mask}) begin
                n_fail++;
                $display("FAIL random_model k=%0d got sw=%h chg=%b mask=%h exp sw=%h chg=%b mask=%h", k, Switches, SwitchChange, SwitchChangeMask, m_sw, m_chg, m_mask);
            end
`ifdef SWITCH_DEBOUNCE_IRQ_EN
            n_checks++;
            if (SwitchIrq !== m_irq) begin
                n_fail++;
                $display("FAIL random_irq k=%0d got irq=%b exp %b", k, SwitchIrq, m_irq);
            end
`endif
        end
        HRESET = 1'b0;
        SwitchIrqClr = 1'b0;
    endtask

    initial begin
        HRESET       = 1'b1;
        SwitchesRaw  = 8'hFF;
        SwitchIrqClr = 1'b0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_independent_bits();
        test_reset_mid_count();
`ifdef SWITCH_DEBOUNCE_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
